instr_prefetch: RTL and testbench

INSTR_PREFETCH -- requirements
Module: instr_prefetch

---
 rtl/instr_prefetch_pkg.sv | 43 ++++
 rtl/instr_prefetch_if.sv | 44 ++++
 rtl/prefetch_fifo.sv | 74 +++++++
 rtl/instr_prefetch.sv | 138 +++++++++++++
 tb/tb_instr_prefetch.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_prefetch_pkg.sv
// instr_prefetch_pkg -- shared constants, types and helpers for the
// instruction prefetcher.
//
// Also provides the ROM start address default (`ROM_START) used as the
// default START_ADDR of instr_prefetch. It is guarded so a project-wide
// definition takes precedence.
//
// Contents:
//   ADDR_W / DATA_W  address and instruction word widths (16)
//   CNT_W            width of the FIFO fill counter (holds 0..8)
//   DEPTH_DEF        default FIFO depth
//   pf_state_e       fetch FSM states (IDLE, REQ, DISCARD)
//   addr_inc()       address increment, wraps FFFF -> 0000

`ifndef ROM_START
`define ROM_START 16'h1000
`endif

package instr_prefetch_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int CNT_W     = 4;
  localparam int DEPTH_DEF = 4;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;

  // IDLE: no request outstanding.
  // REQ: request outstanding, data will be kept.
  // DISCARD: request outstanding but a flush has made its data stale.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } pf_state_e;

  // Plain modular increment; the address space simply wraps.
  function automatic addr_t addr_inc(addr_t a);
    return a + addr_t'(1);
  endfunction

endpackage

// File: rtl/instr_prefetch_if.sv
// instr_prefetch_if -- bus bundle between the prefetcher, the instruction
// ROM, the consumer and the redirect source.
//
// Signals:
//   rom_req / rom_addr     fetch request, held until rom_ack
//   rom_ack / rom_data     ROM response, data valid in the ack cycle
//   flush / flush_addr     one-cycle redirect strobe and its target
//   word_out / word_valid  head-of-FIFO word presented to the consumer
//   word_ready             consumer takes word_out this cycle
//
// Modports:
//   master  prefetcher side
//   slave   ROM / consumer / redirect side

interface instr_prefetch_if;
  import instr_prefetch_pkg::*;

  logic  rom_req;
  addr_t rom_addr;
  logic  rom_ack;
  word_t rom_data;
  logic  flush;
  addr_t flush_addr;
  word_t word_out;
  logic  word_valid;
  logic  word_ready;

  modport master (
    output rom_req, rom_addr,
    input  rom_ack, rom_data,
    input  flush, flush_addr,
    output word_out, word_valid,
    input  word_ready
  );

  modport slave (
    input  rom_req, rom_addr,
    output rom_ack, rom_data,
    output flush, flush_addr,
    input  word_out, word_valid,
    output word_ready
  );

endinterface

// File: rtl/prefetch_fifo.sv
// prefetch_fifo -- instruction word storage for the prefetcher.
//
// Circular buffer of DEPTH (power of two) words with a fill counter.
//
// Ports:
//   ctrl_clk   clock, rising edge
//   reset      asynchronous, active-high; empties the buffer
//   push       write push_data at the tail (ignored when full, no pop)
//   push_data  word to store
//   pop        drop the head word (ignored when empty)
//   clear      empty the buffer; wins over push and pop
//   head_data  head word, forced to zero while empty
//   count      stored entries, 0..DEPTH

module prefetch_fifo
  import instr_prefetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             ctrl_clk,
  input  logic             reset,
  input  logic             push,
  input  word_t            push_data,
  input  logic             pop,
  input  logic             clear,
  output word_t            head_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  word_t            mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty && !clear;
  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign do_push = push && (!full || do_pop) && !clear;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge ctrl_clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while the buffer is empty.
  always_ff @(posedge ctrl_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch.sv
// instr_prefetch -- sequential instruction prefetcher.
//
// Fetches consecutive 16-bit words from the instruction ROM, starting at
// START_ADDR after reset, and queues them in a DEPTH-entry FIFO for the
// consumer. At most one ROM request is outstanding. A flush empties the
// queue, redirects fetching to flush_addr and throws away the data of any
// request already in flight.
//
// Parameters:
//   DEPTH       FIFO entries (power of two, 2..8)
//   START_ADDR  first fetch address after reset
//
// Ports:
//   ctrl_clk    clock, rising edge
//   reset       asynchronous, active-high
//   enabled     high = advance; low = no new requests, no pops
//   bus         instr_prefetch_if.master (ROM, consumer and flush signals)
//   fill_level  stored entry count, 0..DEPTH
//
// Build option:
//   PREFETCH_STATS_EN  adds stat_words (words popped) and stat_flushes
//                      (flushes seen), 16-bit saturating counters.

module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int    DEPTH      = DEPTH_DEF,
  parameter addr_t START_ADDR = `ROM_START
) (
  input  logic             ctrl_clk,
  input  logic             reset,
  input  logic             enabled,
  instr_prefetch_if.master bus,
  output logic [CNT_W-1:0] fill_level
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0]      stat_words,
  output logic [15:0]      stat_flushes
`endif
);

  pf_state_e state;
  pf_state_e state_nxt;
  addr_t     fetch_pc;
  addr_t     fetch_pc_nxt;
  addr_t     rom_addr_q;
  addr_t     rom_addr_nxt;
  logic      outstanding;
  logic      room;
  logic      push;
  logic      pop;

  assign outstanding = (state != ST_IDLE);
  // Only issue a fetch when its word is guaranteed a slot in the FIFO.
  assign room = ({1'b0, fill_level} + {{CNT_W{1'b0}}, outstanding}) < (CNT_W + 1)'(DEPTH);

  // Flush beats a simultaneous pop; a frozen prefetcher does not pop.
  assign pop = bus.word_valid && bus.word_ready && enabled && !bus.flush;

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    rom_addr_nxt = rom_addr_q;
    push         = 1'b0;

    case (state)
      ST_IDLE: begin
        // A flush cycle only loads the new target; fetching resumes next cycle.
        if (!bus.flush && enabled && room) begin
          state_nxt    = ST_REQ;
          rom_addr_nxt = fetch_pc;
        end
      end
      ST_REQ: begin
        if (bus.rom_ack) begin
          state_nxt = ST_IDLE;
          if (!bus.flush) begin
            push         = 1'b1;
            fetch_pc_nxt = addr_inc(fetch_pc);
          end
        end else if (bus.flush) begin
          // Request must still complete on the bus; its data is stale.
          state_nxt = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        if (bus.rom_ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // The newest redirect target always wins, in any state.
    if (bus.flush) fetch_pc_nxt = bus.flush_addr;
  end

  always_ff @(posedge ctrl_clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      fetch_pc   <= START_ADDR;
      rom_addr_q <= START_ADDR;
    end else begin
      state      <= state_nxt;
      fetch_pc   <= fetch_pc_nxt;
      rom_addr_q <= rom_addr_nxt;
    end
  end

  assign bus.rom_req  = outstanding;
  assign bus.rom_addr = rom_addr_q;

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .ctrl_clk  (ctrl_clk),
    .reset     (reset),
    .push      (push),
    .push_data (bus.rom_data),
    .pop       (pop),
    .clear     (bus.flush),
    .head_data (bus.word_out),
    .count     (fill_level)
  );

  assign bus.word_valid = (fill_level != '0);

`ifdef PREFETCH_STATS_EN
  always_ff @(posedge ctrl_clk or posedge reset) begin
    if (reset) begin
      stat_words   <= '0;
      stat_flushes <= '0;
    end else begin
      if (pop && (stat_words != 16'hFFFF))         stat_words   <= stat_words + 16'd1;
      if (bus.flush && (stat_flushes != 16'hFFFF)) stat_flushes <= stat_flushes + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
// tb_instr_prefetch -- self-checking bench for instr_prefetch.
//
// A transaction-level reference model (word queue, one in-flight fetch
// flag with a stale marker, program counter) is stepped once per clock with
// the same inputs driven to the DUT; registered outputs are compared on the
// falling edge. Directed scenarios cover reset, fill to full, pop, flush
// during/with ack, address wrap and freeze; a randomized run follows.

module tb_instr_prefetch;
  import instr_prefetch_pkg::*;

`ifdef ROM_START
  localparam logic [15:0] S = `ROM_START;
`else
  localparam logic [15:0] S = 16'h1000;
`endif
  localparam int DEPTH = 4;

  logic       ctrl_clk = 1'b0;
  logic       reset    = 1'b1;
  logic       enabled  = 1'b0;
  logic [3:0] fill_level;
`ifdef PREFETCH_STATS_EN
  logic [15:0] stat_words;
  logic [15:0] stat_flushes;
`endif

  instr_prefetch_if bus ();

  always #5 ctrl_clk = ~ctrl_clk;

  instr_prefetch #(.DEPTH(DEPTH)) dut (
    .ctrl_clk   (ctrl_clk),
    .reset      (reset),
    .enabled    (enabled),
    .bus        (bus.master),
    .fill_level (fill_level)
`ifdef PREFETCH_STATS_EN
    ,
    .stat_words   (stat_words),
    .stat_flushes (stat_flushes)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  logic [15:0] m_q[$];
  bit          m_busy;
  bit          m_drop;
  logic [15:0] m_addr;
  logic [15:0] m_pc;
  int          m_words;
  int          m_fl;

  logic [15:0] seen[$];
  bit          prev_req;

  function automatic logic [15:0] dfun(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_busy  = 1'b0;
    m_drop  = 1'b0;
    m_addr  = S;
    m_pc    = S;
    m_words = 0;
    m_fl    = 0;
  endtask

  task automatic check_outputs();
    chk("rom_req", 32'(bus.rom_req), 32'(m_busy));
    if (m_busy) chk("rom_addr", 32'(bus.rom_addr), 32'(m_addr));
    chk("word_valid", 32'(bus.word_valid), 32'(m_q.size() != 0));
    chk("word_out", 32'(bus.word_out), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
    chk("fill_level", 32'(fill_level), 32'(m_q.size()));
`ifdef PREFETCH_STATS_EN
    chk("stat_words", 32'(stat_words), 32'(m_words));
    chk("stat_flushes", 32'(stat_flushes), 32'(m_fl));
`endif
    if (bus.rom_req && !prev_req) seen.push_back(bus.rom_addr);
    prev_req = bus.rom_req;
  endtask

  // Drive one cycle of inputs and advance the model across the coming edge.
  task automatic drive_step(input bit en, input bit rdy, input bit fl,
                            input logic [15:0] fa, input bit ack);
    logic [15:0] d;
    bit          pre_busy;
    bit          pre_drop;
    int          pre_n;
    bit          pop;
    d = ack ? dfun(m_addr) : 16'($urandom);
    enabled        = en;
    bus.word_ready = rdy;
    bus.flush      = fl;
    bus.flush_addr = fa;
    bus.rom_ack    = ack;
    bus.rom_data   = d;

    pre_busy = m_busy;
    pre_drop = m_drop;
    pre_n    = m_q.size();
    pop      = en && rdy && (pre_n > 0) && !fl;
    if (fl) m_q.delete();
    else if (pop) void'(m_q.pop_front());
    if (pop && m_words < 65535) m_words++;
    if (fl && m_fl < 65535) m_fl++;
    if (pre_busy) begin
      if (ack) begin
        m_busy = 1'b0;
        m_drop = 1'b0;
        if (!pre_drop && !fl) begin
          m_q.push_back(d);
          m_pc = m_pc + 16'd1;
        end
      end else if (fl) begin
        m_drop = 1'b1;
      end
    end else if (!fl && en && pre_n < DEPTH) begin
      m_busy = 1'b1;
      m_addr = m_pc;
    end
    if (fl) m_pc = fa;
  endtask

  task automatic cyc(input bit en, input bit rdy, input bit fl,
                     input logic [15:0] fa, input bit ack);
    @(negedge ctrl_clk);
    check_outputs();
    drive_step(en, rdy, fl, fa, ack);
  endtask

  task automatic wait_busy(input bit rdy);
    for (int i = 0; i < 20 && !m_busy; i++) cyc(1'b1, rdy, 1'b0, 16'h0, 1'b0);
    if (!m_busy) chk("wait_busy_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lvl0;
    model_reset();
    prev_req       = 1'b0;
    bus.rom_ack    = 1'b0;
    bus.rom_data   = '0;
    bus.flush      = 1'b0;
    bus.flush_addr = '0;
    bus.word_ready = 1'b0;

    // reset state
    repeat (2) @(negedge ctrl_clk);
    chk("rst_req", 32'(bus.rom_req), 32'd0);
    chk("rst_addr", 32'(bus.rom_addr), 32'(S));
    chk("rst_valid", 32'(bus.word_valid), 32'd0);
    chk("rst_word", 32'(bus.word_out), 32'd0);
    chk("rst_fill", 32'(fill_level), 32'd0);
    reset = 1'b0;
    drive_step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);

    // fill to full with ack one cycle after each request
    seen.delete();
    for (int i = 0; i < 14; i++) cyc(1'b1, 1'b0, 1'b0, 16'h0, m_busy);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("fill_n_req", 32'(seen.size()), 32'd4);
    for (int i = 0; i < seen.size() && i < 4; i++)
      chk("fill_addr", 32'(seen[i]), 32'(S + 16'(i)));
    chk("fill_full", 32'(fill_level), 32'd4);
    chk("fill_no_req", 32'(bus.rom_req), 32'd0);

    // one pop from full
    chk("head_first", 32'(bus.word_out), 32'(dfun(S)));
    cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("pop_fill", 32'(fill_level), 32'd3);
    chk("pop_head", 32'(bus.word_out), 32'(dfun(S + 16'd1)));
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("pop_next_req", 32'(bus.rom_req), 32'd1);
    chk("pop_next_addr", 32'(bus.rom_addr), 32'(S + 16'd4));

    // flush while request in flight, ack two cycles later
    cyc(1'b1, 1'b0, 1'b1, 16'h0100, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("disc_hold_req", 32'(bus.rom_req), 32'd1);
    chk("disc_hold_addr", 32'(bus.rom_addr), 32'(S + 16'd4));
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("disc_valid", 32'(bus.word_valid), 32'd0);
    chk("disc_fill", 32'(fill_level), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("disc_new_req", 32'(bus.rom_req), 32'd1);
    chk("disc_new_addr", 32'(bus.rom_addr), 32'h0100);

    // flush coinciding with ack
    cyc(1'b1, 1'b0, 1'b1, 16'h0200, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("flack_req_low", 32'(bus.rom_req), 32'd0);
    chk("flack_valid", 32'(bus.word_valid), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("flack_req", 32'(bus.rom_req), 32'd1);
    chk("flack_addr", 32'(bus.rom_addr), 32'h0200);

    // address wrap
    cyc(1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0);
    seen.delete();
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 1'b0, 16'h0, m_busy);
    chk("wrap_n", 32'(seen.size() >= 3), 32'd1);
    if (seen.size() >= 3) begin
      chk("wrap_a0", 32'(seen[0]), 32'hFFFE);
      chk("wrap_a1", 32'(seen[1]), 32'hFFFF);
      chk("wrap_a2", 32'(seen[2]), 32'h0000);
    end

    // freeze with a request outstanding
    wait_busy(1'b1);
    lvl0 = m_q.size();
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("frz_push", 32'(fill_level), 32'(lvl0 + 1));
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      chk("frz_no_req", 32'(bus.rom_req), 32'd0);
      chk("frz_no_pop", 32'(fill_level), 32'(lvl0 + 1));
    end
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("frz_resume", 32'(bus.rom_req), 32'd1);

    // reset mid-request, then a stray ack
    @(negedge ctrl_clk);
    check_outputs();
    reset       = 1'b1;
    bus.rom_ack = 1'b0;
    #1;
    chk("mid_rst_req", 32'(bus.rom_req), 32'd0);
    chk("mid_rst_fill", 32'(fill_level), 32'd0);
    model_reset();
    prev_req = 1'b0;
    @(negedge ctrl_clk);
    reset = 1'b0;
    drive_step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("stray_ack_fill", 32'(fill_level), 32'd0);
    chk("post_rst_addr", 32'(bus.rom_addr), 32'(S));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit          en;
      bit          rdy;
      bit          fl;
      bit          ack;
      logic [15:0] fa;
      en  = ($urandom_range(0, 7) != 0);
      rdy = ($urandom_range(0, 1) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      fa  = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + 16'($urandom_range(0, 3)))
                                         : 16'($urandom);
      ack = m_busy ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
      cyc(en, rdy, fl, fa, ack);
    end
    @(negedge ctrl_clk);
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
